// File: rtl/elastic_pipe_stage_pkg.sv
// ----------------------------------------------------------------------------
// elastic_pipe_stage_pkg
//   Shared defaults and state encoding for the elastic inter-stage register.
//   PIPE_DATA_BITS / PIPE_CTRL_BITS / PIPE_CNT_BITS : default widths
//   pipe_state_e : EMPTY (main invalid), FULL (main valid), SKID (both valid)
// ----------------------------------------------------------------------------
package elastic_pipe_stage_pkg;

    localparam int PIPE_DATA_BITS = 64;
    localparam int PIPE_CTRL_BITS = 16;
    localparam int PIPE_CNT_BITS  = 16;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
//   Saturating up-counter used for the stage performance counters.
//   clk    in   clock, rising edge
//   rst    in   asynchronous reset, active low
//   i_inc  in   count this cycle
//   i_clr  in   synchronous clear, wins over i_inc
//   o_cnt  out  counter value, sticks at all-ones
// ----------------------------------------------------------------------------
module sat_counter #(
    parameter int CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_inc,
    input  logic                i_clr,
    output logic [CNT_BITS-1:0] o_cnt
);

    logic [CNT_BITS-1:0] cnt_q;
    logic [CNT_BITS-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_cnt = cnt_q;

endmodule

// File: rtl/elastic_pipe_stage.sv
// ----------------------------------------------------------------------------
// elastic_pipe_stage
//   Inter-stage pipeline register with valid/ready handshake, one-entry skid
//   buffer, synchronous flush and saturating stall/bubble counters.
//   clk / rst            clock (rising) / async active-low reset
//   i_flush              squash all held beats (priority over handshakes)
//   i_valid/o_ready      upstream handshake, i_data/i_ctrl payload in
//   o_valid/i_ready      downstream handshake, o_data/o_ctrl payload out
//   i_cnt_clr            clear both counters
//   o_stall_cnt          cycles with o_valid & ~i_ready
//   o_bubble_cnt         cycles with ~o_valid & i_ready
// ----------------------------------------------------------------------------
module elastic_pipe_stage
    import elastic_pipe_stage_pkg::*;
#(
    parameter int DATA_BITS  = PIPE_DATA_BITS,
    parameter int CTRL_BITS  = PIPE_CTRL_BITS,
    parameter int CNT_BITS   = PIPE_CNT_BITS,
    parameter int CLEAR_DATA = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_flush,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [DATA_BITS-1:0] i_data,
    input  logic [CTRL_BITS-1:0] i_ctrl,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [DATA_BITS-1:0] o_data,
    output logic [CTRL_BITS-1:0] o_ctrl,
    input  logic                 i_cnt_clr,
    output logic [CNT_BITS-1:0]  o_stall_cnt,
    output logic [CNT_BITS-1:0]  o_bubble_cnt
);

    pipe_state_e          state_q;
    logic [DATA_BITS-1:0] main_data_q;
    logic [CTRL_BITS-1:0] main_ctrl_q;
    logic [DATA_BITS-1:0] skid_data_q;
    logic [CTRL_BITS-1:0] skid_ctrl_q;

    // Handshake flags are decoded from the state register only, so o_ready
    // never depends combinationally on i_ready.
    logic up_xfer;
    logic dn_xfer;

    assign up_xfer = i_valid & o_ready;
    assign dn_xfer = o_valid & i_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
        end else if (i_flush) begin
            state_q     <= ST_EMPTY;
            main_ctrl_q <= '0;
            skid_ctrl_q <= '0;
            if (CLEAR_DATA != 0) begin
                main_data_q <= '0;
                skid_data_q <= '0;
            end
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (up_xfer) begin
                        main_data_q <= i_data;
                        main_ctrl_q <= i_ctrl;
                        state_q     <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (up_xfer && dn_xfer) begin
                        main_data_q <= i_data;
                        main_ctrl_q <= i_ctrl;
                    end else if (dn_xfer) begin
                        state_q <= ST_EMPTY;
                    end else if (up_xfer) begin
                        // Downstream stalled: park the new beat behind main.
                        skid_data_q <= i_data;
                        skid_ctrl_q <= i_ctrl;
                        state_q     <= ST_SKID;
                    end
                end
                ST_SKID: begin
                    if (dn_xfer) begin
                        main_data_q <= skid_data_q;
                        main_ctrl_q <= skid_ctrl_q;
                        state_q     <= ST_FULL;
                    end
                end
                default: begin
                    state_q <= ST_EMPTY;
                end
            endcase
        end
    end

    assign o_valid = (state_q != ST_EMPTY);
    assign o_ready = (state_q != ST_SKID);
    assign o_data  = main_data_q;
    assign o_ctrl  = o_valid ? main_ctrl_q : '0;

    sat_counter #(
        .CNT_BITS (CNT_BITS)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (o_valid & ~i_ready),
        .i_clr (i_cnt_clr),
        .o_cnt (o_stall_cnt)
    );

    sat_counter #(
        .CNT_BITS (CNT_BITS)
    ) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (~o_valid & i_ready),
        .i_clr (i_cnt_clr),
        .o_cnt (o_bubble_cnt)
    );

endmodule
